// File: rtl/alien_fleet_if.sv
// Game-tick, laser, pixel and status signals between the alien fleet and its neighbours.
interface alien_fleet_if;
  logic       enable;
  logic       laserActive;
  logic [9:0] xLaser;
  logic [9:0] yLaser;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic       killingAlien;
  logic [2:0] colorAlien;
  logic [9:0] xFleet;
  logic [9:0] yFleet;
  logic [5:0] aliveCount;
  logic       fleetCleared;
  logic       fleetLanded;

  modport master (
    output enable, laserActive, xLaser, yLaser, hPos, vPos,
    input  killingAlien, colorAlien, xFleet, yFleet, aliveCount, fleetCleared, fleetLanded
  );

  modport slave (
    input  enable, laserActive, xLaser, yLaser, hPos, vPos,
    output killingAlien, colorAlien, xFleet, yFleet, aliveCount, fleetCleared, fleetLanded
  );
endinterface

// File: rtl/alien_fleet.sv
// Alien formation: laser hit test, alive mask, march FSM, game status and pixel colour.
module alien_fleet #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 8,
  parameter int unsigned H_SPACING    = 64,
  parameter int unsigned V_SPACING    = 32,
  parameter int unsigned ALIEN_W      = 40,
  parameter int unsigned ALIEN_H      = 20,
  parameter int unsigned START_X      = 16,
  parameter int unsigned START_Y      = 32,
  parameter int unsigned H_STEP       = 8,
  parameter int unsigned V_STEP       = 16,
  parameter int unsigned MOVE_PERIOD  = 30,
  parameter int unsigned LAND_Y       = 400,
  parameter int unsigned SCREEN_WIDTH = 640,
  parameter int unsigned BACKGROUND   = 0,
  parameter int unsigned ALIEN        = 2
) (
  input  logic         clk,
  input  logic         reset,
  alien_fleet_if.slave bus
);

  localparam int unsigned N            = ROWS * COLS;
  localparam int unsigned IDX_W        = $clog2(N);
  localparam int unsigned CNT_W        = $clog2(MOVE_PERIOD);
  localparam int unsigned H_SHIFT      = $clog2(H_SPACING);
  localparam int unsigned V_SHIFT      = $clog2(V_SPACING);
  localparam int unsigned RIGHT_REACH  = (COLS - 1) * H_SPACING + ALIEN_W + H_STEP;
  localparam int unsigned BOTTOM_REACH = (ROWS - 1) * V_SPACING + ALIEN_H;

  typedef enum logic [2:0] {MARCH_R, DOWN_L, MARCH_L, DOWN_R, LANDED, CLEARED} state_t;

  state_t             state, state_nxt;
  logic [N-1:0]       alive;
  logic [5:0]         alive_cnt;
  logic               kill;
  logic [2:0]         color;
  logic [9:0]         x_q, y_q, x_nxt, y_nxt;
  logic [CNT_W-1:0]   move_cnt;
  logic               landed_q, cleared_q, landed_nxt, cleared_nxt;

  logic               laser_in_body_c, pix_in_body_c, hit_c;
  logic [IDX_W-1:0]   laser_idx_c, pix_idx_c;
  logic               step_c, edge_r_c, edge_l_c, land_c, marching_c, move_c;

  // Point lies inside an alien body of the full grid anchored at (xf, yf).
  function automatic logic in_body(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] xf, input logic [9:0] yf);
    logic [9:0] dx, dy;
    dx = px - xf;
    dy = py - yf;
    return (px >= xf) && (py >= yf) &&
           ((dx >> H_SHIFT) < 10'(COLS)) && ((dy >> V_SHIFT) < 10'(ROWS)) &&
           ((dx & 10'(H_SPACING - 1)) < 10'(ALIEN_W)) &&
           ((dy & 10'(V_SPACING - 1)) < 10'(ALIEN_H));
  endfunction

  // Alive-mask index of the cell containing the point (meaningful only when in_body).
  function automatic logic [IDX_W-1:0] cell_idx(input logic [9:0] px, input logic [9:0] py,
                                                input logic [9:0] xf, input logic [9:0] yf);
    logic [9:0] row, col;
    row = (py - yf) >> V_SHIFT;
    col = (px - xf) >> H_SHIFT;
    return IDX_W'(row * 10'(COLS) + col);
  endfunction

  assign laser_in_body_c = in_body(bus.xLaser, bus.yLaser, x_q, y_q);
  assign laser_idx_c     = cell_idx(bus.xLaser, bus.yLaser, x_q, y_q);
  assign pix_in_body_c   = in_body(bus.hPos, bus.vPos, x_q, y_q);
  assign pix_idx_c       = cell_idx(bus.hPos, bus.vPos, x_q, y_q);
  assign hit_c = bus.laserActive && !kill && laser_in_body_c && alive[laser_idx_c];

  assign step_c     = (move_cnt == CNT_W'(MOVE_PERIOD - 1));
  assign edge_r_c   = (11'(x_q) + 11'(RIGHT_REACH)) > 11'(SCREEN_WIDTH);
  assign edge_l_c   = x_q < 10'(H_STEP);
  assign land_c     = (11'(y_q) + 11'(BOTTOM_REACH)) >= 11'(LAND_Y);
  assign marching_c = (state == MARCH_R) || (state == DOWN_L) ||
                      (state == MARCH_L) || (state == DOWN_R);
  assign move_c     = bus.enable && marching_c && (alive_cnt != '0) && !land_c && step_c;

  // Hit resolution: clear the struck alien and pulse killingAlien for one enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive     <= '1;
      alive_cnt <= 6'(N);
      kill      <= 1'b0;
    end else if (bus.enable) begin
      kill <= hit_c;
      if (hit_c) begin
        alive[laser_idx_c] <= 1'b0;
        alive_cnt          <= alive_cnt - 6'd1;
      end
    end
  end

  // Pixel colour, one clock behind hPos/vPos.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) color <= 3'(BACKGROUND);
    else        color <= (pix_in_body_c && alive[pix_idx_c]) ? 3'(ALIEN) : 3'(BACKGROUND);
  end

  // Enable counter pacing the march steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          move_cnt <= '0;
    else if (bus.enable) move_cnt <= step_c ? '0 : move_cnt + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MARCH_R;
    else        state <= state_nxt;
  end

  // FSM next state: cleared beats landed, both beat a march step.
  always_comb begin
    state_nxt = state;
    if (bus.enable && marching_c) begin
      if (alive_cnt == '0) state_nxt = CLEARED;
      else if (land_c)     state_nxt = LANDED;
      else if (move_c) begin
        case (state)
          MARCH_R: if (edge_r_c) state_nxt = DOWN_L;
          DOWN_L:  state_nxt = MARCH_L;
          MARCH_L: if (edge_l_c) state_nxt = DOWN_R;
          DOWN_R:  state_nxt = MARCH_R;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // FSM outputs: next fleet position and status flags.
  always_comb begin
    x_nxt       = x_q;
    y_nxt       = y_q;
    landed_nxt  = (state_nxt == LANDED);
    cleared_nxt = (state_nxt == CLEARED);
    if (move_c) begin
      case (state)
        MARCH_R:        if (!edge_r_c) x_nxt = x_q + 10'(H_STEP);
        MARCH_L:        if (!edge_l_c) x_nxt = x_q - 10'(H_STEP);
        DOWN_L, DOWN_R: y_nxt = y_q + 10'(V_STEP);
        default:        x_nxt = x_q;
      endcase
    end
  end

  // Fleet position and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= 10'(START_X);
      y_q       <= 10'(START_Y);
      landed_q  <= 1'b0;
      cleared_q <= 1'b0;
    end else begin
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      landed_q  <= landed_nxt;
      cleared_q <= cleared_nxt;
    end
  end

  assign bus.killingAlien = kill;
  assign bus.colorAlien   = color;
  assign bus.xFleet       = x_q;
  assign bus.yFleet       = y_q;
  assign bus.aliveCount   = alive_cnt;
  assign bus.fleetCleared = cleared_q;
  assign bus.fleetLanded  = landed_q;

endmodule
